ni_code_gen: RTL

NI_CODE_GEN -- requirements
Module: ni_code_gen

---
 rtl/ni_code_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/ni_code_gen.sv
// Neighbourhood-intensity code generator: eight neighbour samples are compared
// against their truncated mean to form an 8-bit code, which addresses a weight ROM.
module ni_code_gen #(
    parameter int FRAME_PIX = 16384
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_nb,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_addr,
    input  logic [23:0] i_lut_dout,
    output logic [7:0]  o_code,
    output logic [23:0] o_weight,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_last,
    output logic [15:0] o_pix_cnt
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 24;
    localparam int NB_N   = 8;
    localparam int SUM_W  = DATA_W + 3;
    localparam logic [15:0] LAST_CNT = 16'(FRAME_PIX - 1);

    logic [NB_N*DATA_W-1:0] nb_p0;
    logic [SUM_W-1:0]       sum_p0;
    logic                   vld_p0;
    logic [NB_N-1:0]        code_p1;
    logic                   vld_p1;
    logic [NB_N-1:0]        code_nxt;
    logic [DATA_W-1:0]      mean;
    logic [15:0]            cnt;
    logic                   stall;

    function automatic logic [SUM_W-1:0] nb_sum(input logic [NB_N*DATA_W-1:0] nb);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < NB_N; k++) begin
            acc = acc + SUM_W'(nb[k*DATA_W +: DATA_W]);
        end
        return acc;
    endfunction

    // Divide by eight with truncation; eight 8-bit samples never overflow SUM_W.
    function automatic logic [DATA_W-1:0] trunc_mean(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:3];
    endfunction

    assign stall     = o_valid && !i_ready;
    assign o_ready   = !stall;
    assign o_addr    = code_p1;
    assign o_pix_cnt = cnt;
    assign o_last    = o_valid && (cnt == LAST_CNT);
    assign mean      = trunc_mean(sum_p0);

    always_comb begin
        code_nxt = '0;
        for (int k = 0; k < NB_N; k++) begin
            code_nxt[k] = (nb_p0[k*DATA_W +: DATA_W] >= mean);
        end
    end

    // Stage 1: capture neighbours and their sum
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p0 <= 1'b0;
            nb_p0  <= '0;
            sum_p0 <= '0;
        end else if (!stall) begin
            vld_p0 <= i_valid;
            if (i_valid) begin
                nb_p0  <= i_nb;
                sum_p0 <= nb_sum(i_nb);
            end
        end
    end

    // Stage 2: threshold each neighbour against the mean
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1  <= 1'b0;
            code_p1 <= '0;
        end else if (!stall) begin
            vld_p1  <= vld_p0;
            code_p1 <= code_nxt;
        end
    end

    // Stage 3: register code with its ROM weight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_code   <= '0;
            o_weight <= '0;
        end else if (!stall) begin
            o_valid  <= vld_p1;
            o_code   <= code_p1;
            o_weight <= i_lut_dout[COEF_W-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (o_valid && i_ready) begin
            cnt <= (cnt == LAST_CNT) ? 16'd0 : cnt + 16'd1;
        end
    end
endmodule
